// File: rtl/cpu_loader.sv
// Program loader and result dumper for the 10-bit CPU: streams a program into
// instruction memory, starts the CPU, waits for done, then streams data memory out.
module cpu_loader #(
   parameter int INSTR_WIDTH = 10,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_DEPTH   = 8,
   parameter int ADDR_WIDTH  = 3,
   parameter int TIMEOUT     = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [INSTR_WIDTH-1:0] s_data,
   input  logic                   s_last,
   output logic                   imem_wr_en,
   output logic [ADDR_WIDTH-1:0]  imem_wr_addr,
   output logic [INSTR_WIDTH-1:0] imem_wr_data,
   output logic                   cpu_start,
   input  logic                   cpu_done,
   output logic                   mem_sel,
   output logic                   dmem_rd_en,
   output logic [ADDR_WIDTH-1:0]  dmem_rd_addr,
   input  logic [DATA_WIDTH-1:0]  dmem_rd_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   m_last,
   output logic                   busy,
   output logic                   err_overflow,
   output logic                   err_timeout
);

   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
      S_RUN   = 3'd1,
      S_WAIT  = 3'd2,
      S_DRD   = 3'd3,
      S_DCAP  = 3'd4,
      S_DHOLD = 3'd5
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [15:0]           CNT_MAX   = 16'(TIMEOUT - 1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [15:0]           cnt;
   logic                  accept;
   logic                  load_end;

   assign accept   = s_valid && s_ready;
   assign load_end = s_last || (ptr == LAST_ADDR);

   // s_ready is a register so it stays low for the first cycle out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_LOAD;
         ptr          <= '0;
         cnt          <= 16'd0;
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
         s_ready      <= 1'b0;
         m_data       <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               s_ready <= 1'b1;
               if (accept) begin
                  if (ptr == '0) begin
                     err_timeout <= 1'b0;
                  end
                  err_overflow <= ((ptr == '0) ? 1'b0 : err_overflow)
                                  | ((ptr == LAST_ADDR) && !s_last);
                  if (load_end) begin
                     ptr     <= '0;
                     state   <= S_RUN;
                     s_ready <= 1'b0;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end
            end
            S_RUN: begin
               cnt   <= 16'd0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cpu_done) begin
                  state <= S_DRD;
               end else if (cnt == CNT_MAX) begin
                  err_timeout <= 1'b1;
                  state       <= S_LOAD;
                  s_ready     <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_DRD: begin
               state <= S_DCAP;
            end
            S_DCAP: begin
               m_data <= dmem_rd_data;
               state  <= S_DHOLD;
            end
            S_DHOLD: begin
               if (m_ready) begin
                  if (ptr == LAST_ADDR) begin
                     ptr     <= '0;
                     state   <= S_LOAD;
                     s_ready <= 1'b1;
                  end else begin
                     ptr   <= ptr + 1'b1;
                     state <= S_DRD;
                  end
               end
            end
            default: begin
               state   <= S_LOAD;
               ptr     <= '0;
               s_ready <= 1'b0;
            end
         endcase
      end
   end

   assign imem_wr_en   = accept;
   assign imem_wr_addr = ptr;
   assign imem_wr_data = s_data;
   assign cpu_start    = (state == S_RUN);
   assign mem_sel      = (state == S_DRD) || (state == S_DCAP) || (state == S_DHOLD);
   assign dmem_rd_en   = (state == S_DRD);
   assign dmem_rd_addr = ptr;
   assign m_valid      = (state == S_DHOLD);
   assign m_last       = (state == S_DHOLD) && (ptr == LAST_ADDR);
   assign busy         = (state != S_LOAD);

endmodule

// File: tb/tb_cpu_loader.sv
// Scoreboard bench for cpu_loader: expected imem writes and dump words are queued
// by the stimulus and popped by a negedge monitor.
module tb_cpu_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid, s_ready, s_last;
   logic [9:0] s_data;
   logic       imem_wr_en;
   logic [2:0] imem_wr_addr;
   logic [9:0] imem_wr_data;
   logic       cpu_start, cpu_done, mem_sel, dmem_rd_en;
   logic [2:0] dmem_rd_addr;
   logic [7:0] dmem_rd_data = 8'h00;
   logic       m_valid, m_ready, m_last, busy, err_overflow, err_timeout;
   logic [7:0] m_data;

   logic [7:0]  dmem [8];
   logic [12:0] exp_w [$];
   logic [8:0]  exp_m [$];
   int          errors = 0;
   int          checks = 0;

   logic        prev_stall = 1'b0, prev_start = 1'b0, prev_last = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   logic [12:0] we;
   logic [8:0]  me;

   always #5 clk = ~clk;

   cpu_loader #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
      .cpu_start(cpu_start), .cpu_done(cpu_done), .mem_sel(mem_sel),
      .dmem_rd_en(dmem_rd_en), .dmem_rd_addr(dmem_rd_addr), .dmem_rd_data(dmem_rd_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
   );

   always @(posedge clk) begin
      if (dmem_rd_en) dmem_rd_data <= dmem[dmem_rd_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   // Monitor: scoreboard pops, stall stability and start-pulse width.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         prev_start = 1'b0;
      end else begin
         if (imem_wr_en) begin
            if (exp_w.size() == 0) flag("imem_unexpected", {19'd0, imem_wr_addr, imem_wr_data});
            else begin
               we = exp_w.pop_front();
               check("imem_addr", imem_wr_addr, we[12:10]);
               check("imem_data", imem_wr_data, we[9:0]);
            end
         end
         if (prev_stall) begin
            check("m_valid_held", m_valid, 1);
            check("m_data_stable", m_data, prev_data);
            check("m_last_stable", m_last, prev_last);
         end
         if (m_valid) check("mem_sel_dump", mem_sel, 1);
         if (cpu_start && prev_start) flag("cpu_start_width", 1);
         if (m_valid && m_ready) begin
            if (exp_m.size() == 0) flag("m_unexpected", {23'd0, m_last, m_data});
            else begin
               me = exp_m.pop_front();
               check("m_data", m_data, me[7:0]);
               check("m_last", m_last, me[8]);
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         prev_start = cpu_start;
      end
   end

   task automatic send(input logic [2:0] addr, input logic [9:0] data, input logic last);
      int n = 0;
      exp_w.push_back({addr, data});
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = data; s_last = last;
      @(negedge clk);
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) flag("send_timeout", {22'd0, data});
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic push_dump();
      for (int i = 0; i < 8; i++) exp_m.push_back({(i == 7) ? 1'b1 : 1'b0, 8'h10 + 8'(i)});
   endtask

   task automatic run_dump(input logic toggle);
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         if (exp_m.size() == 0) break;
         if (toggle) m_ready = ~m_ready;
      end
      check("dump_drained", exp_m.size(), 0);
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = 10'h000; s_last = 1'b0;
      cpu_done = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 8; i++) dmem[i] = 8'h10 + 8'(i);

      // Reset for two edges
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_outputs_1", {s_ready, imem_wr_en, imem_wr_addr, cpu_start, mem_sel, dmem_rd_en,
            dmem_rd_addr, m_valid, m_data, m_last, busy, err_overflow, err_timeout}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs_2", {s_ready, imem_wr_en, imem_wr_addr, cpu_start, mem_sel, dmem_rd_en,
            dmem_rd_addr, m_valid, m_data, m_last, busy, err_overflow, err_timeout}, 0);
      @(negedge clk);
      check("s_ready_after_reset", s_ready, 1);
      check("busy_after_reset", busy, 0);

      // Three-beat program, then dump with toggling backpressure
      send(3'd0, 10'h101, 1'b0);
      send(3'd1, 10'h0A2, 1'b0);
      send(3'd2, 10'h3FF, 1'b1);
      @(negedge clk);
      check("cpu_start_pulse", cpu_start, 1);
      check("s_ready_after_load", s_ready, 0);
      @(negedge clk);
      check("cpu_start_drop", cpu_start, 0);
      check("mem_sel_wait", mem_sel, 0);
      check("busy_wait", busy, 1);
      push_dump();
      m_ready = 1'b1;
      repeat (4) @(negedge clk);
      cpu_done = 1'b1;
      @(posedge clk); #1;
      cpu_done = 1'b0;
      run_dump(1'b1);
      @(negedge clk);
      check("busy_after_dump", busy, 0);
      check("s_ready_after_dump", s_ready, 1);
      check("mem_sel_after_dump", mem_sel, 0);

      // Overflow: eight beats without s_last
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(3'(i), 10'h200 + 10'(i), 1'b0);
      @(negedge clk);
      check("ovf_cpu_start", cpu_start, 1);
      check("ovf_flag", err_overflow, 1);
      s_valid = 1'b1; s_data = 10'h3AA; s_last = 1'b0;
      repeat (3) @(negedge clk);
      check("ninth_beat_refused", s_ready, 0);
      s_valid = 1'b0;
      push_dump();
      cpu_done = 1'b1;
      @(posedge clk); #1;
      cpu_done = 1'b0;
      run_dump(1'b0);
      @(negedge clk);
      check("ovf_sticky", err_overflow, 1);
      send(3'd0, 10'h055, 1'b1);
      @(negedge clk);
      check("ovf_cleared", err_overflow, 0);
      check("ovf_next_start", cpu_start, 1);

      // Timeout with cpu_done low for all 16 WAIT cycles
      for (int k = 1; k <= 16; k++) @(negedge clk);
      check("wait16_no_timeout", err_timeout, 0);
      check("wait16_busy", busy, 1);
      @(negedge clk);
      check("timeout_flag", err_timeout, 1);
      check("timeout_idle", busy, 0);
      check("timeout_s_ready", s_ready, 1);
      check("timeout_no_valid", m_valid, 0);
      cpu_done = 1'b1;
      @(negedge clk);
      cpu_done = 1'b0;
      check("done_ignored_busy", busy, 0);
      check("done_ignored_sel", mem_sel, 0);
      @(negedge clk);
      check("done_ignored_start", cpu_start, 0);

      // Reset while holding a dump word
      m_ready = 1'b0;
      send(3'd0, 10'h123, 1'b1);
      push_dump();
      cpu_done = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cpu_done = 1'b0;
      for (int n = 0; n < 20 && !m_valid; n++) @(negedge clk);
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, 8'h10);
      check("hold_last", m_last, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", m_valid, 0);
      check("rst_mid_sel", mem_sel, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_ready", s_ready, 0);
      exp_m.delete();
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_ready_back", s_ready, 1);
      send(3'd0, 10'h2BC, 1'b1);
      @(negedge clk);
      check("post_reset_start", cpu_start, 1);
      check("imem_all_seen", exp_w.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
